// File: rtl/hilo_muldiv_controller.sv
// hilo_muldiv_controller
//    Multi-cycle multiply/divide sequencer between the EX stage and the
//    64-bit Hi/Lo register.  One operation is in flight at a time.  The
//    result is built one bit per cycle.  It then goes out as a single-cycle
//    write strobe carrying {Hi,Lo}.
//
// Ports
//    Clock          in   system clock, rising edge
//    Reset          in   synchronous active-low reset
//    Start          in   operation request, sampled only in IDLE
//    Op             in   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MSUB 6 MTHI 7 MTLO
//    A              in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//    B              in   rt operand (multiplier / divisor)
//    HiLoIn         in   current Hi/Lo register contents
//    Busy           out  operation in progress (stall Hi/Lo readers)
//    HiLoWrite      out  one-cycle write enable to Hi/Lo
//    HiLoWriteData  out  {Hi,Lo} value, valid while HiLoWrite=1
//    Done           out  one-cycle pulse coincident with HiLoWrite
module hilo_muldiv_controller #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [2:0]           Op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2*WIDTH-1:0]   HiLoIn,
   output logic                 Busy,
   output logic                 HiLoWrite,
   output logic [2*WIDTH-1:0]   HiLoWriteData,
   output logic                 Done
);

   localparam int CW = $clog2(ITER + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DIV   = 3'd2,
      ST_FIX   = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   // Two's-complement negate of an operand-width value when en is set.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   // Two's-complement negate of a double-width value when en is set.
   function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? ({(2*WIDTH){1'b0}} - v) : v;
   endfunction

   state_t               state_r, next_state_s;
   logic [CW-1:0]        cnt_r;
   logic [2:0]           op_r;
   logic [WIDTH-1:0]     a_raw_r;     // unmodified dividend, needed for divide-by-zero
   logic [WIDTH-1:0]     a_r;         // multiplicand magnitude
   logic [WIDTH-1:0]     b_r;         // divisor magnitude
   logic                 neg_q_r;     // product / quotient sign
   logic                 neg_r_r;     // remainder sign (follows dividend)
   logic [2*WIDTH-1:0]   hilo_in_r;
   logic [2*WIDTH-1:0]   prod_r;      // upper half accumulates, lower half holds unused multiplier bits
   logic [WIDTH-1:0]     rem_r;
   logic [WIDTH-1:0]     quo_r;       // starts as dividend, shifts out as quotient shifts in
   logic [2*WIDTH-1:0]   data_r;
   logic                 busy_r, write_r, done_r;

   logic                 signed_op_s, a_neg_s, b_neg_s;
   logic [WIDTH-1:0]     a_mag_s, b_mag_s;
   logic [2*WIDTH-1:0]   mt_data_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH-1:0]   mul_next_s;
   logic [WIDTH:0]       div_shift_s;
   logic                 div_ge_s;
   logic [WIDTH-1:0]     div_diff_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [2*WIDTH-1:0]   fix_data_s;

   assign Busy          = busy_r;
   assign HiLoWrite     = write_r;
   assign HiLoWriteData = data_r;
   assign Done          = done_r;

   // Operand capture: sign/magnitude split and MTHI/MTLO merge.
   always_comb begin
      signed_op_s = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
      a_neg_s     = signed_op_s & A[WIDTH-1];
      b_neg_s     = signed_op_s & B[WIDTH-1];
      a_mag_s     = neg_w(A, a_neg_s);
      b_mag_s     = neg_w(B, b_neg_s);
      if (Op == OP_MTHI) begin
         mt_data_s = {A, HiLoIn[WIDTH-1:0]};
      end else begin
         mt_data_s = {HiLoIn[2*WIDTH-1:WIDTH], A};
      end
   end

   // One shift-add multiply step and one restoring divide step.
   always_comb begin
      mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                    (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
      mul_next_s  = {mul_sum_s, prod_r[WIDTH-1:1]};
      div_shift_s = {rem_r, quo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, b_r});
      // The remainder after a successful subtract is below the divisor, so
      // the low WIDTH bits of the difference are exact.
      div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;
   end

   // Sign correction and accumulate, producing the final {Hi,Lo}.
   always_comb begin
      prod_fix_s = neg_d(prod_r, neg_q_r);
      case (op_r)
         OP_MADD: fix_data_s = hilo_in_r + prod_fix_s;
         OP_MSUB: fix_data_s = hilo_in_r - prod_fix_s;
         OP_DIV, OP_DIVU: begin
            if (b_r == {WIDTH{1'b0}}) begin
               fix_data_s = {a_raw_r, {WIDTH{1'b1}}};
            end else begin
               fix_data_s = {neg_w(rem_r, neg_r_r), neg_w(quo_r, neg_q_r)};
            end
         end
         default: fix_data_s = prod_fix_s;
      endcase
   end

   // Next-state selection.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Start) begin
               case (Op)
                  OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: next_state_s = ST_MUL;
                  OP_DIV, OP_DIVU:                     next_state_s = ST_DIV;
                  OP_MTHI, OP_MTLO:                    next_state_s = ST_WRITE;
                  default:                             next_state_s = ST_IDLE;
               endcase
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cnt_r == CNT_LAST) begin
               next_state_s = ST_FIX;
            end else begin
               next_state_s = ST_MUL;
            end
         end
         ST_DIV: begin
            if (cnt_r == CNT_LAST) begin
               next_state_s = ST_FIX;
            end else begin
               next_state_s = ST_DIV;
            end
         end
         ST_FIX:   next_state_s = ST_WRITE;
         ST_WRITE: next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // State, registered outputs and datapath registers.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         op_r      <= 3'd0;
         a_raw_r   <= {WIDTH{1'b0}};
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         hilo_in_r <= {(2*WIDTH){1'b0}};
         prod_r    <= {(2*WIDTH){1'b0}};
         rem_r     <= {WIDTH{1'b0}};
         quo_r     <= {WIDTH{1'b0}};
         data_r    <= {(2*WIDTH){1'b0}};
         busy_r    <= 1'b0;
         write_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         // Outputs are decoded from the next state so they line up with it.
         busy_r  <= (next_state_s != ST_IDLE);
         write_r <= (next_state_s == ST_WRITE);
         done_r  <= (next_state_s == ST_WRITE);
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  op_r      <= Op;
                  a_raw_r   <= A;
                  a_r       <= a_mag_s;
                  b_r       <= b_mag_s;
                  neg_q_r   <= a_neg_s ^ b_neg_s;
                  neg_r_r   <= a_neg_s;
                  hilo_in_r <= HiLoIn;
                  cnt_r     <= {CW{1'b0}};
                  prod_r    <= {{WIDTH{1'b0}}, b_mag_s};
                  rem_r     <= {WIDTH{1'b0}};
                  quo_r     <= a_mag_s;
                  if ((Op == OP_MTHI) || (Op == OP_MTLO)) begin
                     data_r <= mt_data_s;
                  end
               end
            end
            ST_MUL: begin
               prod_r <= mul_next_s;
               cnt_r  <= cnt_r + CNT_ONE;
            end
            ST_DIV: begin
               rem_r  <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
               quo_r  <= {quo_r[WIDTH-2:0], div_ge_s};
               cnt_r  <= cnt_r + CNT_ONE;
            end
            ST_FIX: begin
               data_r <= fix_data_s;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Self-checking bench for hilo_muldiv_controller: directed cases plus
// random operations compared against an arithmetic reference model.
module tb_hilo_muldiv_controller;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic [63:0] HiLoIn;
   logic        Busy;
   logic        HiLoWrite;
   logic [63:0] HiLoWriteData;
   logic        Done;

   int checks   = 0;
   int failures = 0;

   hilo_muldiv_controller #(.WIDTH(32), .ITER(32)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiLoIn(HiLoIn), .Busy(Busy), .HiLoWrite(HiLoWrite),
      .HiLoWriteData(HiLoWriteData), .Done(Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference result straight from the arithmetic definition of each op.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
      longint sa, sb, sp;
      int     iq, ir, ia, ib;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      case (op)
         3'd0: return 64'(sp);
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            iq = ia / ib;
            ir = ia % ib;
            return {32'(ir), 32'(iq)};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         3'd4: return hl + 64'(sp);
         3'd5: return hl - 64'(sp);
         3'd6: return {a, hl[31:0]};
         default: return {hl[63:32], a};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one op and check timing, strobe count and data.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hl, input string tag);
      logic [63:0] exp, got;
      int exp_busy, busy_n, wr_n, wr_idx;
      bit long_op, done_ok;
      exp      = model(op, a, b, hl);
      long_op  = (op < 3'd6);
      exp_busy = long_op ? 34 : 1;
      got      = 64'd0;
      busy_n   = 0;
      wr_n     = 0;
      wr_idx   = 0;
      done_ok  = 1'b1;
      @(negedge Clock);
      Start = 1'b1; Op = op; A = a; B = b; HiLoIn = hl;
      @(posedge Clock);
      #1;
      // Scramble live inputs: the captured values must be used.
      Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom; HiLoIn = {$urandom, $urandom};
      for (int i = 1; i <= 60; i++) begin
         @(negedge Clock);
         if (Done !== HiLoWrite) done_ok = 1'b0;
         if (HiLoWrite === 1'b1) begin
            wr_n++;
            wr_idx = i;
            got    = HiLoWriteData;
         end
         if (Busy !== 1'b1) break;
         busy_n++;
         // A Start while busy, including during WRITE, must be ignored.
         if (long_op && (i == 3 || HiLoWrite === 1'b1)) begin
            Start = 1'b1; Op = 3'd6;
         end else begin
            Start = 1'b0;
         end
      end
      Start = 1'b0;
      chk({tag, ".data"},   got, exp);
      chk({tag, ".busy"},   64'(busy_n), 64'(exp_busy));
      chk({tag, ".writes"}, 64'(wr_n), 64'd1);
      chk({tag, ".wr_idx"}, 64'(wr_idx), 64'(exp_busy));
      chk({tag, ".done"},   64'(done_ok), 64'd1);
   endtask

   initial begin
      int wr_cnt;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int sel;
      Reset = 1'b0; Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6; HiLoIn = 64'd0;

      // Reset held for two edges with a pending MULT request.
      repeat (2) begin
         @(negedge Clock);
         chk("rst.busy",  64'(Busy), 64'd0);
         chk("rst.write", 64'(HiLoWrite), 64'd0);
         chk("rst.data",  HiLoWriteData, 64'd0);
      end
      Reset = 1'b1; Start = 1'b0;

      run_op(3'd0, 32'd9, 32'hFFFFFFFE, 64'd0, "mult_after_rst");
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, "multu_max");
      run_op(3'd0, 32'hFFFFFFFD, 32'd7, 64'h1234, "mult_neg");
      run_op(3'd4, 32'd2, 32'd3, 64'h00000000_FFFFFFFF, "madd");
      run_op(3'd5, 32'hFFFFFFFF, 32'd5, 64'h10, "msub");
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, 64'd0, "div_neg");
      run_op(3'd3, 32'd7, 32'd0, 64'd0, "divu_zero");
      run_op(3'd2, 32'hFFFFFFF9, 32'd0, 64'd0, "div_zero");
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0, "div_ovf");
      run_op(3'd6, 32'h12345678, 32'd0, 64'hAAAAAAAA_BBBBBBBB, "mthi");
      run_op(3'd7, 32'h87654321, 32'd0, 64'hAAAAAAAA_BBBBBBBB, "mtlo");

      // Reset in the middle of a MULTU aborts it without a write.
      @(negedge Clock);
      Start = 1'b1; Op = 3'd1; A = $urandom; B = $urandom;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      wr_cnt = 0;
      repeat (10) begin
         @(negedge Clock);
         if (HiLoWrite === 1'b1) wr_cnt++;
      end
      Reset = 1'b0;
      @(negedge Clock);
      if (HiLoWrite === 1'b1) wr_cnt++;
      chk("abort.writes", 64'(wr_cnt), 64'd0);
      chk("abort.busy",   64'(Busy), 64'd0);
      chk("abort.data",   HiLoWriteData, 64'd0);
      Reset = 1'b1;
      run_op(3'd1, 32'hDEADBEEF, 32'h12345678, 64'd0, "after_abort");

      // Random ops with a bias toward the corner operands.
      for (int n = 0; n < 30; n++) begin
         rop = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
         else if (sel == 2) begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(1, 5)); end
         run_op(rop, ra, rb, {$urandom, $urandom}, $sformatf("rnd%0d_op%0d", n, rop));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_controller.md
Name: hilo_muldiv_controller

Overview:
- Multi-cycle multiply/divide sequencer that sits between the EX stage and the 64-bit Hi/Lo register.
- Accepts one operation at a time and computes the result iteratively, one bit per cycle.
- Asserts Busy so the hazard unit stalls any MFHI/MFLO or new mul/div.
- Issues a single-cycle write strobe plus 64-bit data ({Hi,Lo}) to the Hi/Lo register.

Parameters:
- WIDTH, 32, operand width; the Hi/Lo result is 2*WIDTH bits.
- ITER, 32, iteration cycles per multiply/divide; must equal WIDTH.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  operation request; sampled only in IDLE.
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- HiLoIn  in  2*WIDTH  current Hi/Lo register contents.
- Busy  out  1  operation in progress; the pipeline must stall Hi/Lo readers.
- HiLoWrite  out  1  one-cycle write enable to the Hi/Lo register.
- HiLoWriteData  out  2*WIDTH  {Hi,Lo} value to write; valid while HiLoWrite=1.
- Done  out  1  one-cycle pulse, coincident with HiLoWrite.

Behaviour:
- Reset=0 at a rising edge:
  - state goes to IDLE; Busy, HiLoWrite and Done go to 0; HiLoWriteData goes to 0; internal registers are cleared.
  - Reset mid-operation aborts it with no write.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE + Start=1 captures A, B, Op and HiLoIn, then branches by Op:
  - Op 0/1/4/5 go to MUL.
  - Op 2/3 go to DIV.
  - Op 6/7 go to WRITE.
  - Operands of signed ops (0, 2, 4, 5) are converted to magnitude plus a result sign at capture.
- MUL: radix-2 shift-add over a 64-bit product register, ITER cycles, then FIX.
- DIV: restoring divide; each cycle shifts the remainder left one bit, subtracts the divisor and sets the quotient bit if the result is non-negative. ITER cycles, then FIX.
- FIX (1 cycle): sign correction.
  - Multiply: negate the product if the operand signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - MADD: add the corrected product to the captured HiLoIn, mod 2^64.
  - MSUB: subtract it from the captured HiLoIn, mod 2^64.
- WRITE (1 cycle):
  - HiLoWrite=1, Done=1; HiLoWriteData is held stable for the whole cycle.
  - Next state is IDLE.
  - Data mapping: multiply gives {Hi,Lo}=product; divide gives Hi=remainder, Lo=quotient; MTHI gives {A, captured Lo}; MTLO gives {captured Hi, A}.
- Busy=1 in MUL, DIV, FIX and WRITE; 0 only in IDLE.
- Latency, with Start accepted at edge N:
  - mul/div: Busy high from N+1; WRITE occupies the cycle after edge N+ITER+1; Busy falls after edge N+ITER+2 (34 Busy cycles).
  - MTHI/MTLO: WRITE in the cycle after edge N (1 Busy cycle).
- Start while Busy=1 is ignored, with no queueing; the hazard unit guarantees this does not happen.
- Start in the same cycle that WRITE completes is not accepted; a back-to-back op may start one cycle after Busy falls.
- Op is ignored unless Start=1.
- Divide by zero (B=0): Hi=dividend A unmodified, Lo=all ones. Takes the full latency. No exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- MADD/MSUB use the HiLoIn captured at Start, not the live HiLoIn.

Test Plan:
- Reset=0 for 2 cycles, then Start with MULT -> during reset Busy=0, HiLoWrite=0, HiLoWriteData=0; after release, normal operation.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 34 Busy cycles a single HiLoWrite with data 0xFFFFFFFE_00000001, Done pulse coincident.
- MULT A=0xFFFFFFFD (-3) B=7 -> 0xFFFFFFFF_FFFFFFEB. Then MADD A=2 B=3 with HiLoIn=0x00000000_FFFFFFFF -> 0x00000001_00000005.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD. DIVU A=7 B=0 -> Hi=0x00000007, Lo=0xFFFFFFFF.
- MTHI A=0x12345678 with HiLoIn=0xAAAAAAAA_BBBBBBBB -> HiLoWrite on the first cycle after Start, data 0x12345678_BBBBBBBB, Busy high exactly 1 cycle.
- Start MULTU, then drop Reset to 0 at iteration 10 -> no HiLoWrite ever asserted; Busy=0 the cycle after the reset edge; a Start on the next cycle after reset release is accepted and completes normally.
